// File: rtl/pc_gen_if.sv
// Fetch-side bundle for pc_gen: redirect requests in, fetch address and status out.
// master = the PC generator, slave = the core/imem side driving redirects and ready.
interface pc_gen_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              trap_enable_i;
   logic [ADDR_W-1:0] trap_addr_i;
   logic              branch_enable_i;
   logic [ADDR_W-1:0] branch_addr_i;
   logic              jump_enable_i;
   logic [ADDR_W-1:0] jump_addr_i;
   logic              stall_i;
   logic              fetch_ready_i;
   logic [ADDR_W-1:0] pc_o;
   logic              ce_o;
   logic              redirect_o;
   logic              misalign_o;
   logic [ADDR_W-1:0] misalign_addr_o;

   modport master (
      input  trap_enable_i, trap_addr_i, branch_enable_i, branch_addr_i,
             jump_enable_i, jump_addr_i, stall_i, fetch_ready_i,
      output pc_o, ce_o, redirect_o, misalign_o, misalign_addr_o
   );

   modport slave (
      output trap_enable_i, trap_addr_i, branch_enable_i, branch_addr_i,
             jump_enable_i, jump_addr_i, stall_i, fetch_ready_i,
      input  pc_o, ce_o, redirect_o, misalign_o, misalign_addr_o
   );
endinterface

// File: rtl/pc_gen.sv
// Program-counter / fetch-address generator: boot delay, prioritised redirects
// (trap > branch > jump), fetch handshake, target alignment check and halt.
module pc_gen #(
   parameter int unsigned ADDR_W      = 32,
   parameter logic [31:0] RESET_ADDR  = 32'h0000_0000,
   parameter int unsigned INST_BYTES  = 4,
   parameter int unsigned BOOT_CYCLES = 2,
   parameter int unsigned ALIGN_CHECK = 1
) (
   input logic       clk_i,
   input logic       rst_i,
   pc_gen_if.master  bus
);
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0]  BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
   localparam logic [ADDR_W-1:0] RST_PC    = ADDR_W'(RESET_ADDR);
   localparam logic [ADDR_W-1:0] INC       = ADDR_W'(INST_BYTES);
   localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'(INST_BYTES - 1);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  boot_cnt_q;
   logic [ADDR_W-1:0] pc_q;
   logic              ce_q;
   logic              redirect_q;
   logic              misalign_q;
   logic [ADDR_W-1:0] misalign_addr_q;

   logic [ADDR_W-1:0] trap_tgt_c;
   logic [ADDR_W-1:0] ctl_tgt_c;
   logic              ctl_en_c;
   logic              ctl_mis_c;

   // Branch wins over jump; traps are forced aligned instead of being checked.
   always_comb begin
      trap_tgt_c = bus.trap_addr_i & ~LOW_MASK;
      ctl_en_c   = bus.branch_enable_i | bus.jump_enable_i;
      ctl_tgt_c  = bus.branch_enable_i ? bus.branch_addr_i : bus.jump_addr_i;
      ctl_mis_c  = (ALIGN_CHECK != 0) && ((ctl_tgt_c & LOW_MASK) != '0);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q         <= ST_BOOT;
         boot_cnt_q      <= '0;
         pc_q            <= RST_PC;
         ce_q            <= 1'b0;
         redirect_q      <= 1'b0;
         misalign_q      <= 1'b0;
         misalign_addr_q <= '0;
      end else begin
         redirect_q <= 1'b0;
         case (state_q)
            ST_BOOT: begin
               if (boot_cnt_q == BOOT_LAST) begin
                  state_q <= ST_RUN;
                  ce_q    <= 1'b1;
               end else begin
                  boot_cnt_q <= boot_cnt_q + CNT_W'(1);
               end
            end
            ST_RUN: begin
               if (bus.trap_enable_i) begin
                  pc_q       <= trap_tgt_c;
                  redirect_q <= 1'b1;
               end else if (ctl_en_c) begin
                  // A bad target freezes fetch at the current PC until a trap.
                  if (ctl_mis_c) begin
                     state_q         <= ST_HALT;
                     ce_q            <= 1'b0;
                     misalign_q      <= 1'b1;
                     misalign_addr_q <= ctl_tgt_c;
                  end else begin
                     pc_q       <= ctl_tgt_c;
                     redirect_q <= 1'b1;
                  end
               end else if (bus.fetch_ready_i && !bus.stall_i) begin
                  pc_q <= pc_q + INC;
               end
            end
            ST_HALT: begin
               if (bus.trap_enable_i) begin
                  state_q    <= ST_RUN;
                  pc_q       <= trap_tgt_c;
                  ce_q       <= 1'b1;
                  redirect_q <= 1'b1;
                  misalign_q <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_BOOT;
               ce_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pc_o            = pc_q;
   assign bus.ce_o            = ce_q;
   assign bus.redirect_o      = redirect_q;
   assign bus.misalign_o      = misalign_q;
   assign bus.misalign_addr_o = misalign_addr_q;
endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed stimulus pushes expected outputs into a scoreboard
// queue; a monitor pops and compares after every sampled edge.
module tb_pc_gen;
   logic clk_i = 1'b0;
   logic rst_i = 1'b0;

   pc_gen_if #(.ADDR_W(32)) if0 ();
   pc_gen_if #(.ADDR_W(32)) if1 ();

   pc_gen #(.ADDR_W(32), .RESET_ADDR(32'h0), .INST_BYTES(4), .BOOT_CYCLES(2), .ALIGN_CHECK(1))
      dut0 (.clk_i(clk_i), .rst_i(rst_i), .bus(if0));
   pc_gen #(.ADDR_W(32), .RESET_ADDR(32'h0), .INST_BYTES(2), .BOOT_CYCLES(3), .ALIGN_CHECK(0))
      dut1 (.clk_i(clk_i), .rst_i(rst_i), .bus(if1));

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          dut;
      string       name;
      logic [31:0] pc;
      logic        ce;
      logic        red;
      logic        mis;
      logic [31:0] maddr;
   } exp_t;

   exp_t q[$];
   event sample_ev;
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic void push_exp(int d, string n, logic [31:0] pc, logic ce,
                                    logic red, logic mis, logic [31:0] ma);
      exp_t e;
      e.dut = d; e.name = n; e.pc = pc; e.ce = ce; e.red = red; e.mis = mis; e.maddr = ma;
      q.push_back(e);
   endfunction

   task automatic drv(logic tr, logic [31:0] ta, logic br, logic [31:0] ba,
                      logic jp, logic [31:0] ja, logic st, logic rd);
      if0.trap_enable_i = tr; if0.trap_addr_i = ta;
      if0.branch_enable_i = br; if0.branch_addr_i = ba;
      if0.jump_enable_i = jp; if0.jump_addr_i = ja;
      if0.stall_i = st; if0.fetch_ready_i = rd;
      if1.trap_enable_i = tr; if1.trap_addr_i = ta;
      if1.branch_enable_i = br; if1.branch_addr_i = ba;
      if1.jump_enable_i = jp; if1.jump_addr_i = ja;
      if1.stall_i = st; if1.fetch_ready_i = rd;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
      -> sample_ev;
      @(negedge clk_i);
   endtask

   // Monitor: compare every queued expectation against the selected DUT.
   initial begin
      exp_t e;
      logic [31:0] a_pc, a_ma;
      logic a_ce, a_red, a_mis;
      forever begin
         @(sample_ev);
         while (q.size() != 0) begin
            e = q.pop_front();
            if (e.dut == 0) begin
               a_pc = if0.pc_o; a_ce = if0.ce_o; a_red = if0.redirect_o;
               a_mis = if0.misalign_o; a_ma = if0.misalign_addr_o;
            end else begin
               a_pc = if1.pc_o; a_ce = if1.ce_o; a_red = if1.redirect_o;
               a_mis = if1.misalign_o; a_ma = if1.misalign_addr_o;
            end
            n_tests++;
            if (a_pc !== e.pc || a_ce !== e.ce || a_red !== e.red ||
                a_mis !== e.mis || a_ma !== e.maddr) begin
               n_fail++;
               $display("FAIL %s dut%0d: got pc=%h ce=%b red=%b mis=%b maddr=%h, want pc=%h ce=%b red=%b mis=%b maddr=%h",
                        e.name, e.dut, a_pc, a_ce, a_red, a_mis, a_ma,
                        e.pc, e.ce, e.red, e.mis, e.maddr);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      drv(0, 0, 0, 0, 0, 0, 0, 1);
      rst_i = 1'b0;
      #1;
      push_exp(0, "reset0", 32'h0, 0, 0, 0, 32'h0);
      push_exp(1, "reset1", 32'h0, 0, 0, 0, 32'h0);
      -> sample_ev;
      @(negedge clk_i);
      rst_i = 1'b1;

      // Boot delay then sequential fetch
      push_exp(0, "boot_e1", 32'h0, 0, 0, 0, 32'h0); tick();
      push_exp(0, "boot_e2", 32'h0, 1, 0, 0, 32'h0); tick();
      push_exp(0, "seq_4",   32'h4, 1, 0, 0, 32'h0); tick();
      push_exp(0, "seq_8",   32'h8, 1, 0, 0, 32'h0); tick();
      push_exp(0, "seq_c",   32'hC, 1, 0, 0, 32'h0); tick();
      push_exp(0, "seq_10",  32'h10, 1, 0, 0, 32'h0); tick();

      // Handshake backpressure and stall
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         push_exp(0, "nready_hold", 32'h10, 1, 0, 0, 32'h0); tick();
      end
      drv(0, 0, 0, 0, 0, 0, 0, 1);
      push_exp(0, "ready_inc", 32'h14, 1, 0, 0, 32'h0); tick();
      drv(0, 0, 0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) begin
         push_exp(0, "stall_hold", 32'h14, 1, 0, 0, 32'h0); tick();
      end
      drv(0, 0, 0, 0, 0, 0, 0, 1);
      push_exp(0, "unstall_inc", 32'h18, 1, 0, 0, 32'h0); tick();

      // Redirect priority
      drv(1, 32'h103, 1, 32'h200, 1, 32'h300, 0, 1);
      push_exp(0, "trap_prio", 32'h100, 1, 1, 0, 32'h0); tick();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      push_exp(0, "red_pulse_end", 32'h100, 1, 0, 0, 32'h0); tick();
      drv(0, 0, 1, 32'h200, 0, 0, 1, 1);
      push_exp(0, "branch_stall", 32'h200, 1, 1, 0, 32'h0); tick();
      drv(0, 0, 0, 0, 0, 0, 1, 1);
      push_exp(0, "branch_after", 32'h200, 1, 0, 0, 32'h0); tick();
      drv(0, 0, 1, 32'h600, 1, 32'h700, 0, 1);
      push_exp(0, "branch_over_jump", 32'h600, 1, 1, 0, 32'h0); tick();

      // Misaligned target halts fetch; trap recovers
      drv(0, 0, 0, 0, 1, 32'h20, 0, 1);
      push_exp(0, "jump_20", 32'h20, 1, 1, 0, 32'h0); tick();
      drv(0, 0, 1, 32'h402, 0, 0, 0, 1);
      push_exp(0, "misalign_halt", 32'h20, 0, 0, 1, 32'h402); tick();
      drv(0, 0, 0, 0, 1, 32'h500, 0, 1);
      push_exp(0, "halt_ign_jump", 32'h20, 0, 0, 1, 32'h402); tick();
      drv(1, 32'h80, 0, 0, 0, 0, 1, 0);
      push_exp(0, "halt_trap", 32'h80, 1, 1, 0, 32'h402); tick();
      drv(0, 0, 0, 0, 0, 0, 0, 1);
      push_exp(0, "after_trap", 32'h84, 1, 0, 0, 32'h402); tick();

      // Address wrap
      drv(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 1);
      push_exp(0, "jump_top", 32'hFFFF_FFFC, 1, 1, 0, 32'h402); tick();
      drv(0, 0, 0, 0, 0, 0, 0, 1);
      push_exp(0, "wrap_0", 32'h0, 1, 0, 0, 32'h402); tick();
      push_exp(0, "wrap_4", 32'h4, 1, 0, 0, 32'h402); tick();

      // Asynchronous reset mid-cycle
      drv(0, 0, 0, 0, 1, 32'h44, 0, 1);
      push_exp(0, "jump_44", 32'h44, 1, 1, 0, 32'h402); tick();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      push_exp(0, "hold_44", 32'h44, 1, 0, 0, 32'h402); tick();
      #2;
      rst_i = 1'b0;
      #1;
      push_exp(0, "async_rst0", 32'h0, 0, 0, 0, 32'h0);
      push_exp(1, "async_rst1", 32'h0, 0, 0, 0, 32'h0);
      -> sample_ev;
      @(negedge clk_i);
      drv(0, 0, 0, 0, 0, 0, 0, 1);
      rst_i = 1'b1;

      // Reboot: dut0 two boot edges, dut1 three
      push_exp(0, "reboot_e1", 32'h0, 0, 0, 0, 32'h0);
      push_exp(1, "boot3_e1",  32'h0, 0, 0, 0, 32'h0); tick();
      push_exp(0, "reboot_e2", 32'h0, 1, 0, 0, 32'h0);
      push_exp(1, "boot3_e2",  32'h0, 0, 0, 0, 32'h0); tick();
      push_exp(0, "reboot_4",  32'h4, 1, 0, 0, 32'h0);
      push_exp(1, "boot3_e3",  32'h0, 1, 0, 0, 32'h0); tick();
      push_exp(0, "reboot_8",  32'h8, 1, 0, 0, 32'h0);
      push_exp(1, "ib2_inc",   32'h2, 1, 0, 0, 32'h0); tick();

      // INST_BYTES=2 wrap and unchecked targets
      drv(0, 0, 0, 0, 1, 32'hFFFF_FFFE, 0, 1);
      push_exp(0, "jump_odd4_halt", 32'h8, 0, 0, 1, 32'hFFFF_FFFE);
      push_exp(1, "ib2_jump_top",   32'hFFFF_FFFE, 1, 1, 0, 32'h0); tick();
      drv(0, 0, 0, 0, 0, 0, 0, 1);
      push_exp(0, "halt_ign_ready", 32'h8, 0, 0, 1, 32'hFFFF_FFFE);
      push_exp(1, "ib2_wrap_0",     32'h0, 1, 0, 0, 32'h0); tick();
      drv(0, 0, 1, 32'h101, 0, 0, 0, 1);
      push_exp(0, "halt_ign_branch", 32'h8, 0, 0, 1, 32'hFFFF_FFFE);
      push_exp(1, "nocheck_odd",     32'h101, 1, 1, 0, 32'h0); tick();
      drv(1, 32'h103, 0, 0, 0, 0, 0, 1);
      push_exp(0, "halt_trap2",  32'h100, 1, 1, 0, 32'hFFFF_FFFE);
      push_exp(1, "ib2_trap_al", 32'h102, 1, 1, 0, 32'h0); tick();
      drv(0, 0, 0, 0, 0, 0, 0, 1);
      push_exp(0, "run_104", 32'h104, 1, 0, 0, 32'hFFFF_FFFE);
      push_exp(1, "ib2_104", 32'h104, 1, 0, 0, 32'h0); tick();

      #2;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
